spi_slave_if: RTL and testbench
===============================

Name: spi_slave_if

Overview:
- Serial front end for the single-port RAM slave. Deserialises MOSI frames into 10-bit command words {cmd[1:0], data[7:0]} and issues them on rx_data/rx_valid.
- Serialises the RAM's 8-bit read result (tx_data/tx_valid) back out on MISO.
- The SPI bit clock is the block clock: one MOSI/MISO bit per clk rising edge while SS_n is low.

Parameters:
- DATA_WIDTH, 8, RAM data/address byte width; rx_data is DATA_WIDTH+2 bits, tx_data is DATA_WIDTH bits.

Ports:
- clk  input  1  system/SPI clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- SS_n  input  1  slave select, active low; frames the transaction
- MOSI  input  1  serial data in, MSB first
- MISO  output  1  serial data out, MSB first
- rx_data  output  DATA_WIDTH+2  assembled command word to RAM
- rx_valid  output  1  one-cycle strobe, rx_data valid
- tx_data  input  DATA_WIDTH  read data from RAM
- tx_valid  input  1  tx_data valid
- cmd_err  output  1  command/state mismatch strobe (see Optional Feature)

Behaviour:
- Reset (rst_n low, async): state=IDLE; MISO=0, rx_data=0, rx_valid=0, cmd_err=0; bit counter=0; rd_addr_seen flag=0.
- States: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE -> CHK_CMD on the first edge sampling SS_n=0.
- CHK_CMD: sample MOSI once (select bit, not stored).
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_seen=0 -> READ_ADD.
  - MOSI=1 and rd_addr_seen=1 -> READ_DATA.
- WRITE / READ_ADD / READ_DATA shift phase: shift 10 MOSI bits MSB first, one per edge.
  - On the edge capturing the 10th bit, rx_data <= {shift[8:0], MOSI} and rx_valid <= 1.
  - rx_valid is high exactly one cycle; rx_data holds its value until the next frame completes.
- Latency: rx_valid rises on the 12th rising edge after the edge that first samples SS_n=0 (1 CHK_CMD edge + 10 data edges, counting from the SS_n-sampling edge as edge 1).
- READ_ADD completion sets rd_addr_seen=1.
- READ_DATA after rx_valid:
  - Wait for tx_valid=1 (any number of cycles); latch tx_data on that edge.
  - Drive MISO with bits [7:0] MSB first on the following 8 edges (bit7 valid after the first edge following the latch).
  - After bit0, MISO=0 and rd_addr_seen clears.
  - Further tx_valid pulses in the same frame are ignored.
- WRITE and READ_ADD frames leave MISO=0 throughout.
- Extra MOSI bits after the 10th within a frame are ignored; no second rx_valid until SS_n returns high and falls again.
- SS_n high sampled in any non-IDLE state -> IDLE on that edge.
  - Bit counter and shift register clear; no rx_valid for a partial frame.
  - MISO=0.
  - rd_addr_seen unchanged unless a READ_DATA transmit completed.
  - An aborted READ_ADD does not set rd_addr_seen.
  - SS_n high in the same cycle as the 10th bit: abort wins, no rx_valid.
- Back-to-back frames: SS_n high for one sampled edge is sufficient to re-arm.
- tx_valid while not in READ_DATA is ignored.
- The block does not decode cmd bits for RAM behaviour; it passes them through unchanged.

Optional Feature:
- Macro SPI_CMD_CHECK_EN.
- Defined: at frame completion, rx_data[9:8] is checked against state.
  - Allowed: WRITE -> 00 or 01; READ_ADD -> 10; READ_DATA -> 11.
  - On mismatch: rx_valid is suppressed, cmd_err pulses high one cycle, rd_addr_seen is unchanged, and the READ_DATA transmit is skipped.
- Undefined: no checking; cmd_err is tied to 0 and every completed frame produces rx_valid.

Test Plan:
- Reset asserted mid-frame (async, between edges) -> all outputs 0 immediately; next frame restarts from CHK_CMD with rd_addr_seen=0.
- SS_n low, MOSI=0 then 00_0000_1010 -> rx_data=0x00A, rx_valid one cycle at the 12th edge; MISO stays 0.
- Read address: MOSI=1 then 10_0000_1010 -> rx_data=0x20A, rd_addr_seen=1. Next frame: MOSI=1 then 11_0000_0000 -> rx_data=0x300; model returns tx_valid with 0xA5 two cycles later -> MISO=1,0,1,0,0,1,0,1; rd_addr_seen=0 afterward.
- Abort: SS_n rises after 6 data bits of a WRITE -> no rx_valid, state IDLE. Next full frame 01_1111_1111 -> rx_data=0x1FF.
- Two READ_ADD frames without a READ_DATA -> second frame with MOSI=1 enters READ_DATA. Frame with MOSI=0 after rd_addr_seen=1 enters WRITE, and the flag persists.
- With SPI_CMD_CHECK_EN: frame select=0, bits 11_0000_0001 -> no rx_valid, cmd_err one-cycle pulse. Without the macro: rx_valid with rx_data=0x301, cmd_err=0.

Source files
------------

// File: rtl/spi_slave_if.sv
// spi_slave_if: SPI serial front end for the single-port RAM slave.
// Deserialises MOSI frames into {cmd[1:0], data} command words (rx_data/rx_valid)
// and serialises the RAM read byte (tx_data/tx_valid) back out on MISO.
// The SPI bit clock is clk: one bit per rising edge while SS_n is low.
// Optional build macro SPI_CMD_CHECK_EN: check the received cmd bits against the
// frame type; a mismatch suppresses rx_valid and pulses cmd_err instead.
// dbg_state exposes the FSM state for observation.
//
// Handshake: rx_valid is a single-cycle strobe qualifying rx_data, which holds
// until the next completed frame. tx_valid qualifies tx_data and is accepted
// only once per READ_DATA frame, after that frame's rx_valid; it is ignored
// at any other time.
module spi_slave_if #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  SS_n,
  input  logic                  MOSI,
  output logic                  MISO,
  output logic [DATA_WIDTH+1:0] rx_data,
  output logic                  rx_valid,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_valid,
  output logic                  cmd_err,
  output logic [2:0]            dbg_state
);

  localparam int RX_W = DATA_WIDTH + 2;
  localparam int CW   = $clog2(RX_W + 1);
  localparam int TCW  = $clog2(DATA_WIDTH + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [RX_W-2:0]       shift_q, shift_d;
  logic [RX_W-1:0]       rx_data_q, rx_data_d;
  logic                  rx_valid_q, rx_valid_d;
  logic                  cmd_err_q, cmd_err_d;
  logic                  miso_q, miso_d;
  logic                  rd_seen_q, rd_seen_d;
  logic                  tx_wait_q, tx_wait_d;
  logic [DATA_WIDTH-1:0] tx_sr_q, tx_sr_d;
  logic [TCW-1:0]        tx_cnt_q, tx_cnt_d;

  logic [RX_W-1:0]       frame_word;
  logic                  cmd_match;

  // The word as it stands on the edge capturing the last bit
  assign frame_word = {shift_q, MOSI};

  // Decide whether the completed command word is acceptable for this frame type
  always_comb begin
    cmd_match = 1'b1;
`ifdef SPI_CMD_CHECK_EN
    case (state_q)
      WRITE:     cmd_match = (frame_word[RX_W-1] == 1'b0);
      READ_ADD:  cmd_match = (frame_word[RX_W-1 -: 2] == 2'b10);
      READ_DATA: cmd_match = (frame_word[RX_W-1 -: 2] == 2'b11);
      default:   cmd_match = 1'b1;
    endcase
`endif
  end

  // Next-state logic for framing, shifting, strobes and the MISO transmit
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = 1'b0;
    cmd_err_d  = 1'b0;
    miso_d     = 1'b0;
    rd_seen_d  = rd_seen_q;
    tx_wait_d  = tx_wait_q;
    tx_sr_d    = tx_sr_q;
    tx_cnt_d   = tx_cnt_q;

    if (state_q == IDLE || SS_n) begin
      // Idle or aborted frame: everything frame-local restarts
      state_d   = (state_q == IDLE && !SS_n) ? CHK_CMD : IDLE;
      cnt_d     = '0;
      shift_d   = '0;
      tx_wait_d = 1'b0;
      tx_cnt_d  = '0;
    end else begin
      case (state_q)
        CHK_CMD: begin
          // Select bit picks the frame type; it is not part of the word
          cnt_d = '0;
          if (!MOSI)          state_d = WRITE;
          else if (rd_seen_q) state_d = READ_DATA;
          else                state_d = READ_ADD;
        end
        default: begin
          if (cnt_q < CW'(RX_W)) begin
            shift_d = {shift_q[RX_W-3:0], MOSI};
            cnt_d   = cnt_q + CW'(1);
            if (cnt_q == CW'(RX_W - 1)) begin
              if (cmd_match) begin
                rx_data_d  = frame_word;
                rx_valid_d = 1'b1;
                if (state_q == READ_ADD)  rd_seen_d = 1'b1;
                if (state_q == READ_DATA) tx_wait_d = 1'b1;
              end else begin
                cmd_err_d = 1'b1;
              end
            end
          end else if (state_q == READ_DATA) begin
            // Frame received: wait for the read byte, then shift it out
            if (tx_wait_q && tx_valid) begin
              tx_sr_d   = tx_data;
              tx_wait_d = 1'b0;
              tx_cnt_d  = TCW'(DATA_WIDTH);
            end else if (tx_cnt_q != '0) begin
              miso_d   = tx_sr_q[DATA_WIDTH-1];
              tx_sr_d  = {tx_sr_q[DATA_WIDTH-2:0], 1'b0};
              tx_cnt_d = tx_cnt_q - TCW'(1);
              if (tx_cnt_q == TCW'(1)) rd_seen_d = 1'b0;
            end
          end
        end
      endcase
    end
  end

  // State and output registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      shift_q    <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      cmd_err_q  <= 1'b0;
      miso_q     <= 1'b0;
      rd_seen_q  <= 1'b0;
      tx_wait_q  <= 1'b0;
      tx_sr_q    <= '0;
      tx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      shift_q    <= shift_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      cmd_err_q  <= cmd_err_d;
      miso_q     <= miso_d;
      rd_seen_q  <= rd_seen_d;
      tx_wait_q  <= tx_wait_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

  assign MISO      = miso_q;
  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  // Without the check, cmd_match is constant 1, so cmd_err stays 0
  assign cmd_err   = cmd_err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spi_slave_if.sv
// Testbench for spi_slave_if: table of frames plus hand-written abort, extra-bit
// and asynchronous reset sequences. Inputs change on the falling edge, outputs
// are sampled on the falling edge.
module tb_spi_slave_if;

  localparam int DW = 8;
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_RA   = 3'd3;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          SS_n = 1'b1;
  logic          MOSI = 1'b0;
  logic          MISO;
  logic [DW+1:0] rx_data;
  logic          rx_valid;
  logic [DW-1:0] tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          cmd_err;
  logic [2:0]    dbg_state;

  // Clock
  always #5 clk = ~clk;

  spi_slave_if #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .cmd_err   (cmd_err),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  // Scoreboard: {is_cmd_err, word} per completed frame, and expected MISO bytes
  logic [10:0]   exp_q[$];
  logic [DW-1:0] tx_exp_q[$];
  bit            m_rd_seen = 1'b0;

  typedef struct {
    bit          sel;
    logic [9:0]  word;
    logic [7:0]  tx;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [2:0] next_state(input bit sel);
    return sel ? (m_rd_seen ? S_RD : S_RA) : S_WR;
  endfunction

  // Monitor: pops the scoreboard on every rx_valid / cmd_err strobe
  logic [10:0] mon_e;
  logic        prev_valid = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_valid) chk("rx_valid_one_cycle", 32'(rx_valid), 32'd0);
      if (rx_valid || cmd_err) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", 32'({rx_valid, cmd_err}), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          if (mon_e[10]) begin
            chk("cmd_err_strobe", 32'({cmd_err, rx_valid}), 32'b10);
          end else begin
            chk("rx_strobe", 32'({cmd_err, rx_valid}), 32'b01);
            chk("rx_data", 32'(rx_data), 32'(mon_e[9:0]));
          end
        end
      end
      prev_valid = rx_valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // Drive one frame starting at a falling edge: SS_n low, select bit, nbits data bits
  task automatic frame(input bit sel, input logic [9:0] word, input int nbits,
                       input bit abort_last, input logic [2:0] exp_state, output bit err);
    bit miso_ok;
    bit strobe;
    miso_ok = 1'b1;
    err = 1'b0;
`ifdef SPI_CMD_CHECK_EN
    case (exp_state)
      S_WR:    err = word[9];
      S_RA:    err = (word[9:8] != 2'b10);
      S_RD:    err = (word[9:8] != 2'b11);
      default: err = 1'b0;
    endcase
`endif
    strobe = (nbits >= 10) && !abort_last;
    if (strobe) exp_q.push_back({err, word});
    SS_n = 1'b0;
    MOSI = 1'($urandom_range(0, 1));
    @(negedge clk);
    MOSI = sel;
    @(negedge clk);
    chk("state_after_select", 32'(dbg_state), 32'(exp_state));
    for (int i = 0; i < nbits; i++) begin
      if (i > 0) @(negedge clk);
      if (MISO !== 1'b0) miso_ok = 1'b0;
      MOSI = (i < 10) ? word[9 - i] : 1'($urandom_range(0, 1));
      tx_valid = (i == 3);
      tx_data = 8'($urandom_range(0, 255));
      if (abort_last && i == nbits - 1) SS_n = 1'b1;
    end
    @(negedge clk);
    tx_valid = 1'b0;
    if (MISO !== 1'b0) miso_ok = 1'b0;
    if (nbits == 10) chk("rx_valid_at_edge12", 32'(rx_valid), 32'(strobe && !err));
    chk("miso_low_during_rx", 32'(miso_ok), 32'd1);
  endtask

  // Return the read byte two cycles after rx_valid and collect it from MISO
  task automatic run_tx(input logic [7:0] b);
    logic [7:0] got;
    got = '0;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = b;
    tx_exp_q.push_back(b);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data = ~b;
    chk("miso_before_bit7", 32'(MISO), 32'd0);
    for (int i = 7; i >= 0; i--) begin
      @(negedge clk);
      got[i] = MISO;
      tx_valid = (i == 5);
    end
    @(negedge clk);
    tx_valid = 1'b0;
    chk("miso_after_bit0", 32'(MISO), 32'd0);
    chk("miso_byte", 32'(got), 32'(tx_exp_q.pop_front()));
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    chk("late_tx_valid_ignored", 32'(MISO), 32'd0);
  endtask

  task automatic end_frame();
    SS_n = 1'b1;
    MOSI = 1'b0;
    @(negedge clk);
    chk("idle_after_ss_high", 32'(dbg_state), 32'(S_IDLE));
  endtask

  // Full frame with model update and, for READ_DATA, the transmit phase
  task automatic do_frame(input bit sel, input logic [9:0] word, input logic [7:0] tx);
    logic [2:0] st;
    bit err;
    st = next_state(sel);
    frame(sel, word, 10, 1'b0, st, err);
    if (!err) begin
      if (st == S_RA) m_rd_seen = 1'b1;
      if (st == S_RD) begin
        run_tx(tx);
        m_rd_seen = 1'b0;
      end
    end
    end_frame();
  endtask

  initial begin
    vec_t       vecs[11];
    logic [2:0] st;
    bit         err;

    vecs[0]  = '{1'b0, 10'h00A, 8'h00};
    vecs[1]  = '{1'b1, 10'h20A, 8'h00};
    vecs[2]  = '{1'b1, 10'h300, 8'hA5};
    vecs[3]  = '{1'b1, 10'h2FF, 8'h00};
    vecs[4]  = '{1'b0, 10'h1C3, 8'h00};
    vecs[5]  = '{1'b1, 10'h3FF, 8'h3C};
    vecs[6]  = '{1'b1, 10'h255, 8'h00};
    vecs[7]  = '{1'b1, 10'h2A0, 8'h5A};
    vecs[8]  = '{1'b0, 10'h301, 8'h00};
    vecs[9]  = '{1'b1, 10'h281, 8'h81};
    vecs[10] = '{1'b1, 10'h300, 8'($urandom_range(0, 255))};

    // Reset
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_miso", 32'(MISO), 32'd0);
    chk("reset_rx_data", 32'(rx_data), 32'd0);
    chk("reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("reset_cmd_err", 32'(cmd_err), 32'd0);
    chk("reset_state", 32'(dbg_state), 32'(S_IDLE));
    rst_n = 1'b1;

    // Table of frames, back to back with one SS_n-high edge between them
    for (int k = 0; k < 11; k++) begin
      do_frame(vecs[k].sel, vecs[k].word, vecs[k].tx);
    end

    // WRITE aborted after 6 data bits, then a full frame
    frame(1'b0, 10'h0AA, 6, 1'b0, S_WR, err);
    end_frame();
    do_frame(1'b0, 10'h1FF, 8'h00);

    // SS_n rises together with the 10th bit: no strobe, flag untouched
    st = next_state(1'b1);
    frame(1'b1, 10'h2AA, 10, 1'b1, st, err);
    chk("idle_after_last_bit_abort", 32'(dbg_state), 32'(S_IDLE));
    do_frame(1'b1, 10'h2C3, 8'h96);

    // Extra MOSI bits after the 10th are ignored
    st = next_state(1'b0);
    frame(1'b0, 10'h0F0, 14, 1'b0, st, err);
    end_frame();

    // Asynchronous reset in the middle of a READ_DATA transmit
    if (!m_rd_seen) do_frame(1'b1, 10'h2C0, 8'h00);
    st = next_state(1'b1);
    frame(1'b1, 10'h300, 10, 1'b0, st, err);
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data = 8'hFF;
    @(negedge clk);
    tx_valid = 1'b0;
    @(negedge clk);
    chk("miso_bit7_before_reset", 32'(MISO), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_reset_miso", 32'(MISO), 32'd0);
    chk("async_reset_rx_data", 32'(rx_data), 32'd0);
    chk("async_reset_rx_valid", 32'(rx_valid), 32'd0);
    chk("async_reset_state", 32'(dbg_state), 32'(S_IDLE));
    m_rd_seen = 1'b0;
    SS_n = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    do_frame(1'b1, 10'h2AB, 8'h00);

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
